// File: rtl/axilite_slave_regfile_pkg.sv
// Shared types and constants for the AXI4-Lite slave register file.
package axilite_slave_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         WAIT_W      = 4;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;

endpackage

// File: rtl/axilite_slave_regfile_if.sv
// AXI4-Lite bus bundle; slave modport is what the register file sits on.
interface axilite_slave_regfile_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );
endinterface

// File: rtl/axilite_slave_wait_cnt.sv
// Wait-state counter: load a count, decrement towards zero, done while at zero.
module axilite_slave_wait_cnt
  import axilite_slave_regfile_pkg::*;
(
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              done
);

  logic [WAIT_W-1:0] cnt_reg;
  logic [WAIT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - WAIT_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign done = (cnt_reg == '0);

endmodule

// File: rtl/axilite_slave_regfile.sv
// AXI4-Lite slave register file with byte strobes, programmable wait states,
// SLVERR on unmapped accesses and completed-transaction counters.
module axilite_slave_regfile
  import axilite_slave_regfile_pkg::*;
#(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter int                NUM_REGS      = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter int                WAIT_CYCLES   = 0,
  parameter logic [DATA_W-1:0] UNMAPPED_DATA = DATA_W'(32'h01234567)
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  axilite_slave_regfile_if.slave        s_axi,
  output logic [15:0]                   wr_count,
  output logic [15:0]                   rd_count
);

  localparam int                NBYTES     = DATA_W / 8;
  localparam int                SH         = $clog2(NBYTES);
  localparam int                IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [WAIT_W-1:0] WAIT_VAL   = WAIT_W'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  logic [DATA_W-1:0] regs_reg [NUM_REGS];

  // ---------------- write channel state ----------------
  wr_state_t         wr_state_reg, wr_state_next;
  logic              aw_got_reg, aw_got_next;
  logic              w_got_reg, w_got_next;
  logic [ADDR_W-1:0] awaddr_reg, awaddr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [NBYTES-1:0] wstrb_reg, wstrb_next;
  logic              awready_reg, awready_next;
  logic              wready_reg, wready_next;
  logic              bvalid_reg, bvalid_next;
  logic [1:0]        bresp_reg, bresp_next;
  logic [15:0]       wr_count_reg, wr_count_next;
  logic              wr_load, wr_dec, wr_done, wr_commit;
  logic              aw_hs, w_hs, aw_done, w_done;

  // ---------------- read channel state ----------------
  rd_state_t         rd_state_reg, rd_state_next;
  logic [ADDR_W-1:0] araddr_reg, araddr_next;
  logic              arready_reg, arready_next;
  logic              rvalid_reg, rvalid_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic [1:0]        rresp_reg, rresp_next;
  logic [15:0]       rd_count_reg, rd_count_next;
  logic              rd_load, rd_dec, rd_done;

  // Address decode works on the captured addresses, so it never reaches an output combinationally.
  logic [ADDR_W-1:0] wr_off, rd_off;
  logic              wr_mapped, rd_mapped;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  assign wr_off    = (awaddr_reg - BASE_ADDR) >> SH;
  assign wr_mapped = (awaddr_reg >= BASE_ADDR) && (wr_off < NUM_REGS_A);
  assign wr_idx    = wr_off[IDX_W-1:0];
  assign rd_off    = (araddr_reg - BASE_ADDR) >> SH;
  assign rd_mapped = (araddr_reg >= BASE_ADDR) && (rd_off < NUM_REGS_A);
  assign rd_idx    = rd_off[IDX_W-1:0];

  logic [DATA_W-1:0] wr_mask;
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    assign wr_mask[gi*8 +: 8] = {8{wstrb_reg[gi]}};
  end

  axilite_slave_wait_cnt u_wr_wait (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .load     (wr_load),
    .load_val (WAIT_VAL),
    .dec      (wr_dec),
    .done     (wr_done)
  );

  axilite_slave_wait_cnt u_rd_wait (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .load     (rd_load),
    .load_val (WAIT_VAL),
    .dec      (rd_dec),
    .done     (rd_done)
  );

  assign aw_hs   = s_axi.awvalid && awready_reg;
  assign w_hs    = s_axi.wvalid && wready_reg;
  assign aw_done = aw_got_reg || aw_hs;
  assign w_done  = w_got_reg || w_hs;

  // W_WAIT always lasts at least one cycle: it is the commit stage, giving k+1+WAIT_CYCLES.
  always_comb begin
    wr_state_next = wr_state_reg;
    aw_got_next   = aw_got_reg;
    w_got_next    = w_got_reg;
    awaddr_next   = awaddr_reg;
    wdata_next    = wdata_reg;
    wstrb_next    = wstrb_reg;
    awready_next  = awready_reg;
    wready_next   = wready_reg;
    bvalid_next   = bvalid_reg;
    bresp_next    = bresp_reg;
    wr_count_next = wr_count_reg;
    wr_load       = 1'b0;
    wr_dec        = 1'b0;
    wr_commit     = 1'b0;
    case (wr_state_reg)
      W_IDLE: begin
        awready_next = !aw_done;
        wready_next  = !w_done;
        if (aw_hs) awaddr_next = s_axi.awaddr;
        if (w_hs) begin
          wdata_next = s_axi.wdata;
          wstrb_next = s_axi.wstrb;
        end
        if (aw_done && w_done) begin
          aw_got_next   = 1'b0;
          w_got_next    = 1'b0;
          wr_load       = 1'b1;
          wr_state_next = W_WAIT;
        end else begin
          aw_got_next = aw_done;
          w_got_next  = w_done;
        end
      end
      W_WAIT: begin
        wr_dec = 1'b1;
        if (wr_done) begin
          wr_commit     = 1'b1;
          bvalid_next   = 1'b1;
          bresp_next    = wr_mapped ? RESP_OKAY : RESP_SLVERR;
          wr_state_next = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          bvalid_next   = 1'b0;
          awready_next  = 1'b1;
          wready_next   = 1'b1;
          wr_count_next = wr_count_reg + 16'd1;
          wr_state_next = W_IDLE;
        end
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_reg <= W_IDLE;
      aw_got_reg   <= 1'b0;
      w_got_reg    <= 1'b0;
      awaddr_reg   <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
      wr_count_reg <= '0;
    end else begin
      wr_state_reg <= wr_state_next;
      aw_got_reg   <= aw_got_next;
      w_got_reg    <= w_got_next;
      awaddr_reg   <= awaddr_next;
      wdata_reg    <= wdata_next;
      wstrb_reg    <= wstrb_next;
      awready_reg  <= awready_next;
      wready_reg   <= wready_next;
      bvalid_reg   <= bvalid_next;
      bresp_reg    <= bresp_next;
      wr_count_reg <= wr_count_next;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
    end else if (wr_commit && wr_mapped) begin
      regs_reg[wr_idx] <= (regs_reg[wr_idx] & ~wr_mask) | (wdata_reg & wr_mask);
    end
  end

  // A read sampled on the commit edge sees the pre-write contents.
  always_comb begin
    rd_state_next = rd_state_reg;
    araddr_next   = araddr_reg;
    arready_next  = arready_reg;
    rvalid_next   = rvalid_reg;
    rdata_next    = rdata_reg;
    rresp_next    = rresp_reg;
    rd_count_next = rd_count_reg;
    rd_load       = 1'b0;
    rd_dec        = 1'b0;
    case (rd_state_reg)
      R_IDLE: begin
        arready_next = 1'b1;
        if (s_axi.arvalid && arready_reg) begin
          araddr_next   = s_axi.araddr;
          arready_next  = 1'b0;
          rd_load       = 1'b1;
          rd_state_next = R_WAIT;
        end
      end
      R_WAIT: begin
        rd_dec = 1'b1;
        if (rd_done) begin
          rvalid_next   = 1'b1;
          rdata_next    = rd_mapped ? regs_reg[rd_idx] : UNMAPPED_DATA;
          rresp_next    = rd_mapped ? RESP_OKAY : RESP_SLVERR;
          rd_state_next = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi.rready) begin
          rvalid_next   = 1'b0;
          arready_next  = 1'b1;
          rd_count_next = rd_count_reg + 16'd1;
          rd_state_next = R_IDLE;
        end
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_reg <= R_IDLE;
      araddr_reg   <= '0;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= '0;
      rresp_reg    <= RESP_OKAY;
      rd_count_reg <= '0;
    end else begin
      rd_state_reg <= rd_state_next;
      araddr_reg   <= araddr_next;
      arready_reg  <= arready_next;
      rvalid_reg   <= rvalid_next;
      rdata_reg    <= rdata_next;
      rresp_reg    <= rresp_next;
      rd_count_reg <= rd_count_next;
    end
  end

  assign s_axi.awready = awready_reg;
  assign s_axi.wready  = wready_reg;
  assign s_axi.bvalid  = bvalid_reg;
  assign s_axi.bresp   = bresp_reg;
  assign s_axi.arready = arready_reg;
  assign s_axi.rvalid  = rvalid_reg;
  assign s_axi.rdata   = rdata_reg;
  assign s_axi.rresp   = rresp_reg;
  assign wr_count      = wr_count_reg;
  assign rd_count      = rd_count_reg;

endmodule

// File: tb/tb_axilite_slave_regfile.sv
// Directed bench: vector table on a zero-wait instance plus hand sequences
// for wait states, same-edge read/write and reset while a response is pending.
module tb_axilite_slave_regfile;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axilite_slave_regfile_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  axilite_slave_regfile_if #(.ADDR_W(32), .DATA_W(32)) b4 ();

  logic [15:0] wr_cnt0, rd_cnt0, wr_cnt4, rd_cnt4;

  axilite_slave_regfile #(
    .ADDR_W(32), .DATA_W(32), .NUM_REGS(16), .BASE_ADDR(32'h0),
    .WAIT_CYCLES(0), .UNMAPPED_DATA(32'h01234567)
  ) dut0 (
    .aclk(aclk), .aresetn(aresetn), .s_axi(b0.slave),
    .wr_count(wr_cnt0), .rd_count(rd_cnt0)
  );

  axilite_slave_regfile #(
    .ADDR_W(32), .DATA_W(32), .NUM_REGS(16), .BASE_ADDR(32'h100),
    .WAIT_CYCLES(4), .UNMAPPED_DATA(32'h01234567)
  ) dut4 (
    .aclk(aclk), .aresetn(aresetn), .s_axi(b4.slave),
    .wr_count(wr_cnt4), .rd_count(rd_cnt4)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output bit to);
    int  n;
    bit  aw_pend, w_pend, aw_hs, w_hs;
    n = 0; aw_pend = 1'b1; w_pend = 1'b1; to = 1'b0; resp = '0;
    b0.awaddr = addr; b0.awvalid = 1'b1;
    b0.wdata = data; b0.wstrb = strb; b0.wvalid = 1'b1;
    b0.bready = 1'b1;
    while ((aw_pend || w_pend) && n < 50) begin
      aw_hs = aw_pend && b0.awready;
      w_hs  = w_pend && b0.wready;
      @(posedge aclk); #1; n++;
      if (aw_hs) begin b0.awvalid = 1'b0; aw_pend = 1'b0; end
      if (w_hs)  begin b0.wvalid  = 1'b0; w_pend  = 1'b0; end
    end
    b0.awvalid = 1'b0; b0.wvalid = 1'b0;
    while (!b0.bvalid && n < 50) begin @(posedge aclk); #1; n++; end
    if (!b0.bvalid || aw_pend || w_pend) to = 1'b1;
    else begin
      resp = b0.bresp;
      @(posedge aclk); #1;
    end
    b0.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output bit to);
    int n;
    bit hs;
    n = 0; hs = 1'b0; to = 1'b0; data = '0; resp = '0;
    b0.araddr = addr; b0.arvalid = 1'b1; b0.rready = 1'b1;
    while (!hs && n < 50) begin
      hs = b0.arready;
      @(posedge aclk); #1; n++;
    end
    b0.arvalid = 1'b0;
    while (!b0.rvalid && n < 50) begin @(posedge aclk); #1; n++; end
    if (!b0.rvalid || !hs) to = 1'b1;
    else begin
      data = b0.rdata;
      resp = b0.rresp;
      @(posedge aclk); #1;
    end
    b0.rready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    bit          to;
    int          e;

    vecs[0]  = '{1'b1, 32'h08, 32'hA5A5A5A5, 4'b0011, 32'h0,        2'b00};
    vecs[1]  = '{1'b0, 32'h08, 32'h0,        4'b0000, 32'h0000A5A5, 2'b00};
    vecs[2]  = '{1'b1, 32'h0C, 32'hDEADBEEF, 4'b1111, 32'h0,        2'b00};
    vecs[3]  = '{1'b1, 32'h0E, 32'h11223344, 4'b1000, 32'h0,        2'b00};
    vecs[4]  = '{1'b0, 32'h0C, 32'h0,        4'b0000, 32'h11ADBEEF, 2'b00};
    vecs[5]  = '{1'b0, 32'h3C, 32'h0,        4'b0000, 32'h00000000, 2'b00};
    vecs[6]  = '{1'b0, 32'h40, 32'h0,        4'b0000, 32'h01234567, 2'b10};
    vecs[7]  = '{1'b1, 32'h40, 32'hFFFFFFFF, 4'b1111, 32'h0,        2'b10};
    vecs[8]  = '{1'b0, 32'h08, 32'h0,        4'b0000, 32'h0000A5A5, 2'b00};
    vecs[9]  = '{1'b0, 32'h0C, 32'h0,        4'b0000, 32'h11ADBEEF, 2'b00};
    vecs[10] = '{1'b1, 32'h3C, 32'hCAFEF00D, 4'b0101, 32'h0,        2'b00};
    vecs[11] = '{1'b0, 32'h3C, 32'h0,        4'b0000, 32'h00FE000D, 2'b00};
    vecs[12] = '{1'b0, 32'h1000, 32'h0,      4'b0000, 32'h01234567, 2'b10};

    b0.awaddr = '0; b0.awvalid = 0; b0.wdata = '0; b0.wstrb = '0; b0.wvalid = 0;
    b0.bready = 0; b0.araddr = '0; b0.arvalid = 0; b0.rready = 0;
    b4.awaddr = '0; b4.awvalid = 0; b4.wdata = '0; b4.wstrb = '0; b4.wvalid = 0;
    b4.bready = 0; b4.araddr = '0; b4.arvalid = 0; b4.rready = 0;

    // Reset state
    aresetn = 1'b0;
    repeat (5) @(posedge aclk);
    #1;
    check("rst_out0", {b0.awready, b0.wready, b0.arready, b0.bvalid, b0.rvalid, b0.bresp, b0.rresp}, 0);
    check("rst_rdata0", b0.rdata, 0);
    check("rst_cnt0", {wr_cnt0, rd_cnt0}, 0);
    check("rst_out4", {b4.awready, b4.wready, b4.arready, b4.bvalid, b4.rvalid, b4.bresp, b4.rresp, b4.rdata}, 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("rdy_after_rst0", {b0.awready, b0.wready, b0.arready}, 3'b111);
    check("rdy_after_rst4", {b4.awready, b4.wready, b4.arready}, 3'b111);
    $display("txn reset release: ready outputs sampled");

    // Same-edge commit and read sample of register 2
    b0.awaddr = 32'h8; b0.wdata = 32'h11; b0.wstrb = 4'hF; b0.araddr = 32'h8;
    b0.awvalid = 1; b0.wvalid = 1; b0.arvalid = 1; b0.bready = 0; b0.rready = 0;
    @(posedge aclk); #1;
    b0.awvalid = 0; b0.wvalid = 0; b0.arvalid = 0;
    check("hs_ready_drop", {b0.awready, b0.wready, b0.arready}, 3'b000);
    @(posedge aclk); #1;
    check("same_edge_valid", {b0.bvalid, b0.rvalid}, 2'b11);
    check("same_edge_rdata", b0.rdata, 32'h0);
    check("same_edge_resp", {b0.bresp, b0.rresp}, 4'b0000);
    b0.bready = 1; b0.rready = 1;
    @(posedge aclk); #1;
    b0.bready = 0; b0.rready = 0;
    check("same_edge_cnt", {wr_cnt0, rd_cnt0}, {16'd1, 16'd1});
    do_read(32'h8, rd, rs, to);
    check("same_edge_to", to, 0);
    check("same_edge_reread", rd, 32'h11);
    $display("txn same-edge write/read reg2: rdata=0x%0h then 0x%0h", 0, rd);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs, to);
        check($sformatf("vec%0d_wr_to", i), to, 0);
        check($sformatf("vec%0d_bresp", i), rs, vecs[i].exp_resp);
        $display("txn vec%0d write addr=0x%0h data=0x%0h strb=%b bresp=%b", i,
                 vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
      end else begin
        do_read(vecs[i].addr, rd, rs, to);
        check($sformatf("vec%0d_rd_to", i), to, 0);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
        check($sformatf("vec%0d_rresp", i), rs, vecs[i].exp_resp);
        $display("txn vec%0d read addr=0x%0h rdata=0x%0h rresp=%b", i, vecs[i].addr, rd, rs);
      end
    end
    check("table_counts", {wr_cnt0, rd_cnt0}, {16'd6, 16'd10});

    // WAIT_CYCLES=4 instance: W leads AW by 3 cycles, bready held low
    b4.wdata = 32'h55667788; b4.wstrb = 4'hF; b4.wvalid = 1; b4.bready = 0;
    @(posedge aclk); #1;
    b4.wvalid = 0;
    repeat (2) @(posedge aclk);
    #1;
    b4.awaddr = 32'h104; b4.awvalid = 1;
    @(posedge aclk); #1;
    b4.awvalid = 0;
    e = 0;
    while (!b4.bvalid && e < 20) begin @(posedge aclk); #1; e++; end
    check("wait4_b_latency", e, 5);
    for (int c = 0; c < 3; c++) begin
      @(posedge aclk); #1;
      check($sformatf("wait4_b_hold%0d", c), {b4.bvalid, b4.bresp}, 3'b100);
    end
    b4.bready = 1;
    @(posedge aclk); #1;
    b4.bready = 0;
    check("wait4_b_done", {b4.bvalid, wr_cnt4}, {1'b0, 16'd1});
    $display("txn wait4 write addr=0x104 bvalid after %0d edges", e);

    b4.araddr = 32'h104; b4.arvalid = 1; b4.rready = 0;
    @(posedge aclk); #1;
    b4.arvalid = 0;
    e = 0;
    while (!b4.rvalid && e < 20) begin @(posedge aclk); #1; e++; end
    check("wait4_r_latency", e, 5);
    check("wait4_rdata", {b4.rdata, b4.rresp}, {32'h55667788, 2'b00});
    b4.rready = 1;
    @(posedge aclk); #1;
    b4.rready = 0;
    check("wait4_r_done", {b4.rvalid, rd_cnt4}, {1'b0, 16'd1});
    $display("txn wait4 read addr=0x104 rvalid after %0d edges", e);

    // Reset while a read response waits for rready
    b0.araddr = 32'h8; b0.arvalid = 1; b0.rready = 0;
    @(posedge aclk); #1;
    b0.arvalid = 0;
    @(posedge aclk); #1;
    check("pre_rst_rvalid", b0.rvalid, 1'b1);
    #2;
    aresetn = 1'b0;
    #1;
    check("rst_rvalid_drop", {b0.rvalid, b0.rdata}, 0);
    b0.rready = 1;
    repeat (2) @(posedge aclk);
    #1;
    b0.rready = 0;
    check("rst_rd_count", rd_cnt0, 16'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    do_read(32'h8, rd, rs, to);
    check("post_rst_to", to, 0);
    check("post_rst_reg", rd, 32'h0);
    check("post_rst_rd_count", rd_cnt0, 16'd1);
    $display("txn reset during rvalid: reread rdata=0x%0h", rd);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
